nes_spr_dma: RTL and testbench

NES_SPR_DMA -- requirements
Module: nes_spr_dma

---
 rtl/nes_bus_pkg.sv | 26 ++
 rtl/nes_spr_dma.sv | 103 ++++++++++
 tb/tb_nes_spr_dma.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants and the sprite-DMA state encoding.
// Ports: none (package). Imported by nes_spr_dma.
// Config: NES_SPR_DMA_ALIGN_EN adds the ALIGN state to the encoding.
package nes_bus_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

`ifdef NES_SPR_DMA_ALIGN_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;
`endif

endpackage

// File: rtl/nes_spr_dma.sv
// Sprite (OAM) DMA master: a write to $4014 copies page {wdata,00..FF} to $2004.
// Ports: i_clk/i_rst; i_bus_* snoop for the trigger; o_spr_req/i_spr_gnt arbitration;
//        o_spr_addr/o_spr_wn/o_spr_wdata/i_spr_rdata master bus; o_busy status.
// Config: NES_SPR_DMA_ALIGN_EN adds the odd-cycle ALIGN dummy read and the parity flop.
module nes_spr_dma
  import nes_bus_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_spr_req,
  input  logic        i_spr_gnt,
  output logic [15:0] o_spr_addr,
  output logic        o_spr_wn,
  output logic [7:0]  o_spr_wdata,
  input  logic [7:0]  i_spr_rdata,
  output logic        o_busy
);

  dma_state_t state, state_nxt;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data;
  logic       trig;

  // Only snoop the bus while we are not mastering it ourselves.
  assign trig = (state == ST_IDLE) && !i_bus_wn && (i_bus_addr == ADDR_OAMDMA);

`ifdef NES_SPR_DMA_ALIGN_EN
  // Free-running CPU cycle parity; odd in HALT costs one extra dummy read.
  logic parity;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) parity <= 1'b0;
    else       parity <= ~parity;
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      page  <= 8'h00;
      idx   <= 8'h00;
      data  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (trig) begin
        page <= i_bus_wdata;
        idx  <= 8'h00;
      end
      // Nothing moves on a cycle the arbiter withholds the bus.
      if (i_spr_gnt) begin
        if (state == ST_READ)  data <= i_spr_rdata;
        if (state == ST_WRITE) idx  <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    o_spr_addr  = 16'h0000;
    o_spr_wn    = 1'b1;
    o_spr_wdata = 8'h00;
    case (state)
      ST_IDLE: begin
        if (trig) state_nxt = ST_HALT;
      end
      ST_HALT: begin
        o_spr_addr = {page, 8'h00};
        if (i_spr_gnt) begin
`ifdef NES_SPR_DMA_ALIGN_EN
          state_nxt = parity ? ST_ALIGN : ST_READ;
`else
          state_nxt = ST_READ;
`endif
        end
      end
`ifdef NES_SPR_DMA_ALIGN_EN
      ST_ALIGN: begin
        o_spr_addr = {page, 8'h00};
        if (i_spr_gnt) state_nxt = ST_READ;
      end
`endif
      ST_READ: begin
        o_spr_addr = {page, idx};
        if (i_spr_gnt) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        o_spr_addr  = ADDR_OAMDATA;
        o_spr_wn    = 1'b0;
        o_spr_wdata = data;
        if (i_spr_gnt) state_nxt = (idx == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_spr_req = (state != ST_IDLE);
  assign o_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_nes_spr_dma.sv
// Directed bench for nes_spr_dma: even/odd parity transfers, grant stall,
// back-to-back triggers, bus noise while busy, and mid-transfer reset.
module tb_nes_spr_dma;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        spr_req;
  logic        spr_gnt;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;
  logic        busy;
  logic        corrupt;

  int n_cmp = 0;
  int n_bad = 0;
  int pcnt;
  bit halt_odd;

  typedef struct {
    logic [15:0] a;
    logic        wn;
    logic [7:0]  d;
  } ent_t;
  ent_t q[$];

  nes_spr_dma dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_bus_addr  (bus_addr),
    .i_bus_wn    (bus_wn),
    .i_bus_wdata (bus_wdata),
    .o_spr_req   (spr_req),
    .i_spr_gnt   (spr_gnt),
    .o_spr_addr  (spr_addr),
    .o_spr_wn    (spr_wn),
    .o_spr_wdata (spr_wdata),
    .i_spr_rdata (spr_rdata),
    .o_busy      (busy)
  );

  always #5 i_clk = ~i_clk;

  // Memory: byte at offset n holds n ^ A5; garbage while the grant is withheld.
  always_comb spr_rdata = corrupt ? 8'h3C : (spr_addr[7:0] ^ 8'hA5);

  // Cycles since reset release; its LSB tracks the CPU parity.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pcnt <= 0;
    else       pcnt <= pcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus_addr  = 16'h0000;
    bus_wn    = 1'b1;
    bus_wdata = 8'h00;
  endtask

  // Called at a negedge: drives the $4014 write for this cycle.
  task automatic drive_trig(input logic [7:0] pg);
    bus_addr  = 16'h4014;
    bus_wn    = 1'b0;
    bus_wdata = pg;
    halt_odd  = !pcnt[0];
  endtask

  task automatic run_xfer(input logic [7:0] pg, input bit pre_trig, input bit want_odd,
                          input bit stall, input bit noise, input bit chain,
                          input logic [7:0] chain_pg, input string tag);
    int dummy, reqc, bad, stall_left, base;
    bit stall_done, seen, done;
    logic [15:0] end_addr;
    logic end_wn, end_busy;
    logic [7:0] end_wdata;
    ent_t e;
    q.delete();
    reqc = 0; bad = 0; stall_left = 0; stall_done = 0; seen = 0; done = 0;
    end_addr = 16'hFFFF; end_wn = 1'b0; end_busy = 1'b1; end_wdata = 8'hFF;
    if (!pre_trig) begin
      @(negedge i_clk);
      if ((!pcnt[0]) != want_odd) @(negedge i_clk);
      drive_trig(pg);
    end
    dummy = 1;
`ifdef NES_SPR_DMA_ALIGN_EN
    if (halt_odd) dummy = 2;
`endif
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge i_clk);
      bus_idle();
      if (spr_req) begin
        reqc++;
        seen = 1;
        if (noise && reqc == 10) begin
          bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = 8'h77;
        end
        if (stall && !stall_done && spr_wn && spr_addr == {pg, 8'h10}) begin
          stall_left = 4;
          stall_done = 1;
        end
        if (stall_left > 0) begin
          spr_gnt = 1'b0;
          corrupt = 1'b1;
          if (spr_addr !== {pg, 8'h10} || spr_wn !== 1'b1) bad++;
          stall_left--;
        end else begin
          spr_gnt = 1'b1;
          corrupt = 1'b0;
          q.push_back('{spr_addr, spr_wn, spr_wdata});
        end
      end else begin
        done = 1;
        if (seen) begin
          end_addr = spr_addr; end_wn = spr_wn; end_wdata = spr_wdata; end_busy = busy;
          if (chain) drive_trig(chain_pg);
        end
      end
    end
    spr_gnt = 1'b1;
    corrupt = 1'b0;
    chk({tag, "_finished"}, {31'd0, done && seen}, 32'd1);
    chk({tag, "_req_cycles"}, reqc, 512 + dummy + (stall ? 4 : 0));
    chk({tag, "_gnt_cycles"}, q.size(), 512 + dummy);
    for (int i = 0; i < dummy; i++) begin
      if (i < q.size()) begin
        e = q[i];
        if (e.a !== {pg, 8'h00} || e.wn !== 1'b1) bad++;
      end else bad++;
    end
    for (int k = 0; k < 256; k++) begin
      base = dummy + 2 * k;
      if (base + 1 < q.size()) begin
        e = q[base];
        if (e.a !== {pg, k[7:0]} || e.wn !== 1'b1) bad++;
        e = q[base + 1];
        if (e.a !== 16'h2004 || e.wn !== 1'b0 || e.d !== (k[7:0] ^ 8'hA5)) bad++;
      end else bad++;
    end
    chk({tag, "_seq_errors"}, bad, 0);
    if (q.size() > 0) begin
      e = q[q.size() - 1];
      chk({tag, "_last_wdata"}, e.d, 8'h5A);
    end else chk({tag, "_last_wdata"}, 32'hDEAD, 8'h5A);
    chk({tag, "_idle_out"}, {end_busy, end_wn, end_wdata, end_addr}, {1'b0, 1'b1, 8'h00, 16'h0000});
  endtask

  initial begin
    int wr_cnt, stray;
    bit hit;
    i_rst = 1'b1;
    spr_gnt = 1'b1;
    corrupt = 1'b0;
    halt_odd = 1'b0;
    bus_idle();
    repeat (3) @(negedge i_clk);
    chk("rst_req", spr_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", spr_addr, 16'h0000);
    chk("rst_wn", spr_wn, 1'b1);
    chk("rst_wdata", spr_wdata, 8'h00);
    i_rst = 1'b0;

    run_xfer(8'h02, 0, 0, 0, 1, 0, 8'h00, "even");
    run_xfer(8'h02, 0, 1, 0, 0, 0, 8'h00, "odd");
    run_xfer(8'h04, 0, 0, 1, 0, 0, 8'h00, "stall");
    run_xfer(8'h02, 0, 0, 0, 0, 1, 8'h03, "b2b_a");
    run_xfer(8'h03, 1, 0, 0, 0, 0, 8'h00, "b2b_b");

    // Reset during the WRITE of idx 80.
    @(negedge i_clk);
    drive_trig(8'h05);
    wr_cnt = 0;
    hit = 0;
    for (int cyc = 0; cyc < 1000 && !hit; cyc++) begin
      @(negedge i_clk);
      bus_idle();
      if (spr_req && !spr_wn) begin
        if (wr_cnt == 128) begin
          hit = 1;
          chk("mid_wdata", spr_wdata, 8'h80 ^ 8'hA5);
          i_rst = 1'b1;
          #1;
          chk("mid_rst_req", spr_req, 1'b0);
          chk("mid_rst_addr", spr_addr, 16'h0000);
          chk("mid_rst_wn", spr_wn, 1'b1);
          chk("mid_rst_busy", busy, 1'b0);
        end
        wr_cnt++;
      end
    end
    chk("mid_rst_reached", {31'd0, hit}, 32'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (spr_req || busy) stray++;
    end
    chk("post_rst_quiet", stray, 0);
    run_xfer(8'h01, 0, 1, 0, 0, 0, 8'h00, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
